// File: rtl/audio_frame_pkg.sv
// Shared types and constants for the audio frame collector.
// Optional drop counter enabled by AUDIO_FRAME_DROP_COUNT_EN.
package audio_frame_pkg;

    localparam int FRAME_LEN = 480;
    localparam int SAMPLE_W  = 32;
    localparam int IDX_W     = 9;
    localparam int ENERGY_W  = 25;

    localparam logic [ENERGY_W-1:0] ENERGY_THRESH_DEF = 25'd400000;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef sample_t frame_t [FRAME_LEN];

    typedef enum logic {
        FILL,
        WAIT_SWAP
    } wr_state_t;

    // -32768 maps to 32768, which still fits the unsigned 16-bit result
    function automatic logic [15:0] mag16(input logic [15:0] hi);
        return hi[15] ? (~hi + 16'd1) : hi;
    endfunction

endpackage

// File: rtl/frame_energy_acc.sv
// Abs-magnitude energy accumulator with clear/add and threshold compare.
// "above" reflects the sum including the sample being added this cycle.
module frame_energy_acc
    import audio_frame_pkg::*;
#(
    parameter logic [ENERGY_W-1:0] THRESH = ENERGY_THRESH_DEF
) (
    input  logic                Clk,
    input  logic                Reset_h,
    input  logic                clr,
    input  logic                add,
    input  logic [15:0]         hi,
    output logic [ENERGY_W-1:0] energy,
    output logic                above
);

    logic [ENERGY_W-1:0] total;

    always_comb begin
        total = energy;
        if (add)
            total = energy + ENERGY_W'(mag16(hi));
        above = (total >= THRESH);
    end

    always_ff @(posedge Clk) begin
        if (Reset_h || clr)
            energy <= '0;
        else if (add)
            energy <= total;
    end

endmodule

// File: rtl/audio_frame_collector.sv
// Ping-pong frame collector feeding the pitch engine.
// Define AUDIO_FRAME_DROP_COUNT_EN to add the drop_count output.
module audio_frame_collector
    import audio_frame_pkg::*;
#(
    parameter logic [ENERGY_W-1:0] ENERGY_THRESH = ENERGY_THRESH_DEF
) (
    input  logic          Clk,
    input  logic          Reset_h,
    input  logic [31:0]   sample_in,
    input  logic          sample_valid,
    input  logic          frame_done,
    output frame_t        soundOut,
    output logic          inBlock,
    output logic          isVoice,
`ifdef AUDIO_FRAME_DROP_COUNT_EN
    output logic [15:0]   drop_count,
`endif
    output logic          overrun
);

    wr_state_t           state;
    logic                wr_bank;
    logic                rd_bank;
    logic [IDX_W-1:0]    wr_idx;
    logic                accept;
    logic                last;
    logic                drop;
    logic                swap;
    logic                voice;
    logic [ENERGY_W-1:0] energy;

    sample_t mem [2][FRAME_LEN];

    assign rd_bank = ~wr_bank;

    always_comb begin
        accept = 1'b0;
        drop   = 1'b0;
        unique case (state)
            FILL:      accept = sample_valid;
            WAIT_SWAP: drop   = sample_valid;
            default: ;
        endcase
        last = accept && (wr_idx == IDX_W'(FRAME_LEN - 1));
        swap = (last && (!inBlock || frame_done))
            || ((state == WAIT_SWAP) && frame_done);
    end

    frame_energy_acc #(
        .THRESH (ENERGY_THRESH)
    ) u_energy (
        .Clk     (Clk),
        .Reset_h (Reset_h),
        .clr     (swap),
        .add     (accept),
        .hi      (sample_in[31:16]),
        .energy  (energy),
        .above   (voice)
    );

    // Storage has no reset; consumers gate on inBlock
    always_ff @(posedge Clk) begin
        if (accept)
            mem[wr_bank][wr_idx] <= sample_in;
    end

    always_comb begin
        for (int k = 0; k < FRAME_LEN; k++)
            soundOut[k] = mem[rd_bank][k];
    end

    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            state   <= FILL;
            wr_bank <= 1'b0;
            wr_idx  <= '0;
            inBlock <= 1'b0;
            isVoice <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (drop)
                overrun <= 1'b1;
            if (swap) begin
                wr_bank <= ~wr_bank;
                wr_idx  <= '0;
                isVoice <= voice;
                inBlock <= 1'b1;
                state   <= FILL;
            end else begin
                if (inBlock && frame_done)
                    inBlock <= 1'b0;
                if (last)
                    state <= WAIT_SWAP;
                else if (accept)
                    wr_idx <= wr_idx + IDX_W'(1);
            end
        end
    end

`ifdef AUDIO_FRAME_DROP_COUNT_EN
    always_ff @(posedge Clk) begin
        if (Reset_h || swap)
            drop_count <= '0;
        else if (drop && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
    end
`endif

    logic unused_ok;
    assign unused_ok = ^energy;

endmodule

// File: tb/tb_audio_frame_collector.sv
// Directed self-checking bench for audio_frame_collector.
// Build with AUDIO_FRAME_DROP_COUNT_EN to also check drop_count.
module tb_audio_frame_collector;
    import audio_frame_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_h = 1'b1;
    logic [31:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        frame_done = 1'b0;
    frame_t      soundOut;
    logic        inBlock;
    logic        isVoice;
    logic        overrun;
`ifdef AUDIO_FRAME_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    audio_frame_collector dut (
        .Clk          (Clk),
        .Reset_h      (Reset_h),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .frame_done   (frame_done),
        .soundOut     (soundOut),
        .inBlock      (inBlock),
        .isVoice      (isVoice),
`ifdef AUDIO_FRAME_DROP_COUNT_EN
        .drop_count   (drop_count),
`endif
        .overrun      (overrun)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // Stimulus patterns
    function automatic logic [31:0] pat(input int kind, input int i);
        logic [31:0] v;
        case (kind)
            0: v = 32'(i) << 16;
            1: v = 32'h7FFF0000;
            2: v = 32'(-((i + 1) * 65536));
            3: v = 32'h80000000;
            default: v = 32'(i + 7) << 16;
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [31:0] s, input logic fd);
        sample_in    = s;
        sample_valid = 1'b1;
        frame_done   = fd;
        tick();
        sample_valid = 1'b0;
        frame_done   = 1'b0;
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
    endtask

    task automatic chk_frame(input string tag, input int kind);
        int errs;
        errs = 0;
        for (int k = 0; k < FRAME_LEN; k++)
            if (soundOut[k] !== pat(kind, k))
                errs++;
        chk(tag, 32'(errs), 32'd0);
    endtask

    int lows;

    initial begin
        tick();
        tick();
        Reset_h = 1'b0;
        chk("rst_inblock", 32'(inBlock), 32'd0);
        chk("rst_voice", 32'(isVoice), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
`ifdef AUDIO_FRAME_DROP_COUNT_EN
        chk("rst_dropcnt", 32'(drop_count), 32'd0);
`endif

        // ramp frame: energy 114960, below threshold
        for (int i = 0; i < FRAME_LEN - 1; i++)
            send(pat(0, i), 1'b0);
        chk("f0_early", 32'(inBlock), 32'd0);
        send(pat(0, FRAME_LEN - 1), 1'b0);
        chk("f0_inblock", 32'(inBlock), 32'd1);
        chk_frame("f0_data", 0);
        chk("f0_voice", 32'(isVoice), 32'd0);
        chk("f0_overrun", 32'(overrun), 32'd0);

        pulse_done();
        chk("rel_inblock", 32'(inBlock), 32'd0);
        chk("rel_voice", 32'(isVoice), 32'd0);

        // loud frame: energy 15728160
        for (int i = 0; i < FRAME_LEN; i++)
            send(pat(1, i), 1'b0);
        chk("f1_inblock", 32'(inBlock), 32'd1);
        chk("f1_voice", 32'(isVoice), 32'd1);
        chk_frame("f1_data", 1);

        // fill second bank while first is held, then 5 drops
        for (int i = 0; i < FRAME_LEN; i++)
            send(pat(2, i), 1'b0);
        for (int i = 0; i < 5; i++)
            send(32'h12345678, 1'b0);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_inblock", 32'(inBlock), 32'd1);
        chk_frame("ovr_hold", 1);
`ifdef AUDIO_FRAME_DROP_COUNT_EN
        chk("ovr_dropcnt", 32'(drop_count), 32'd5);
`endif
        pulse_done();
        chk("sw_inblock", 32'(inBlock), 32'd1);
        chk_frame("sw_data", 2);
        chk("sw_voice", 32'(isVoice), 32'd0);
`ifdef AUDIO_FRAME_DROP_COUNT_EN
        chk("sw_dropcnt", 32'(drop_count), 32'd0);
`endif

        // done coincides with the last sample: swap, no gap, no drop
        lows = 0;
        for (int i = 0; i < FRAME_LEN - 1; i++) begin
            send(pat(3, i), 1'b0);
            if (inBlock !== 1'b1)
                lows++;
        end
        send(pat(3, FRAME_LEN - 1), 1'b1);
        chk("co_gap", 32'(lows), 32'd0);
        chk("co_inblock", 32'(inBlock), 32'd1);
        chk_frame("co_data", 3);
        chk("co_voice", 32'(isVoice), 32'd1);
        chk("co_overrun", 32'(overrun), 32'd1);
`ifdef AUDIO_FRAME_DROP_COUNT_EN
        chk("co_dropcnt", 32'(drop_count), 32'd0);
`endif

        pulse_done();
        chk("rel2_inblock", 32'(inBlock), 32'd0);
        chk("rel2_voice", 32'(isVoice), 32'd1);
        pulse_done();
        chk("idle_inblock", 32'(inBlock), 32'd0);
        chk("idle_voice", 32'(isVoice), 32'd1);

        // reset mid-frame discards the partial frame
        for (int i = 0; i < 200; i++)
            send(32'h55550000, 1'b0);
        Reset_h = 1'b1;
        tick();
        Reset_h = 1'b0;
        chk("mrst_inblock", 32'(inBlock), 32'd0);
        chk("mrst_voice", 32'(isVoice), 32'd0);
        chk("mrst_overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 280; i++)
            send(pat(4, i), 1'b0);
        chk("mrst_early", 32'(inBlock), 32'd0);
        for (int i = 280; i < FRAME_LEN; i++)
            send(pat(4, i), 1'b0);
        chk("mrst_inblock2", 32'(inBlock), 32'd1);
        chk_frame("mrst_data", 4);
        chk("mrst_voice2", 32'(isVoice), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
